// File: rtl/viterbi_pkg.sv
// Shared Viterbi constants, trellis helpers and the traceback FSM encoding.
package viterbi_pkg;

    localparam int K_DEF        = 3;
    localparam int TBL_DEF      = 15;
    localparam int PM_WIDTH_DEF = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_t;

    function automatic int ns(input int k);
        return 1 << (k - 1);
    endfunction

    // Predecessor of next-state s given its decision bit d: {s[K-3:0], d}.
    function automatic int pred_idx(input int s, input logic d, input int k);
        return ((s << 1) | int'(d)) & (ns(k) - 1);
    endfunction

endpackage

// File: rtl/tbu_argmin.sv
// Combinational minimum-index tree over NS unsigned metrics; ties go to the lowest index.
module tbu_argmin #(
    parameter int NS = 4,
    parameter int W  = 8,
    parameter int IW = $clog2(NS)
) (
    input  logic [NS*W-1:0] i_pm,
    output logic [IW-1:0]   o_idx
);
    localparam int LG = $clog2(NS);

    for (genvar l = 0; l <= LG; l++) begin : g_lvl
        localparam int N = NS >> l;
        logic [N*W-1:0]  w_v;
        logic [N*IW-1:0] w_x;

        if (l == 0) begin : g_leaf
            assign w_v = i_pm;
            for (genvar i = 0; i < N; i++) begin : g_i
                assign w_x[i*IW +: IW] = IW'(i);
            end
        end else begin : g_node
            for (genvar i = 0; i < N; i++) begin : g_i
                logic [W-1:0] w_a, w_b;
                logic         w_pick_b;
                assign w_a = g_lvl[l-1].w_v[(2*i)*W +: W];
                assign w_b = g_lvl[l-1].w_v[(2*i+1)*W +: W];
                // Left child always holds the lower indices, so only a strict win moves right.
                assign w_pick_b = (w_b < w_a);
                assign w_v[i*W +: W]   = w_pick_b ? w_b : w_a;
                assign w_x[i*IW +: IW] = w_pick_b ? g_lvl[l-1].w_x[(2*i+1)*IW +: IW]
                                                  : g_lvl[l-1].w_x[(2*i)*IW +: IW];
            end
        end
    end

    assign o_idx = g_lvl[LG].w_x;

endmodule

// File: rtl/tbu_flush.sv
// Register-exchange traceback unit with frame-end survivor drain.
// Define TBU_TAIL_TERM_EN to drain the state-0 survivor (zero-tailed encoder) instead of the best one.
module tbu_flush
    import viterbi_pkg::*;
#(
    parameter int K        = K_DEF,
    parameter int TBL      = TBL_DEF,
    parameter int PM_WIDTH = PM_WIDTH_DEF,
    parameter int CNT_W    = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic                        last_i,
    input  logic [ns(K)-1:0]            dec_bits_i,
    input  logic [ns(K)*PM_WIDTH-1:0]   pm_i,
    output logic                        data_o,
    output logic                        valid_o,
    output logic                        last_o,
    output logic                        busy_o
);
    localparam int               NS    = ns(K);
    localparam int               IW    = K - 1;
    localparam logic [CNT_W-1:0] TBL_C = CNT_W'(TBL);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    fsm_t                    r_state, w_state_nxt;
    logic [NS-1:0][TBL-1:0]  r_path, w_path_nxt;
    logic [CNT_W-1:0]        r_n, w_n_inc, r_rem, w_rem_ld;
    logic [TBL-1:0]          r_drain, w_drain_ld, w_sel_path;
    logic [IW-1:0]           w_best, w_sel;
    logic                    w_acc, w_full;
    logic                    r_data, r_valid, r_last;
    logic                    w_data_nxt, w_valid_nxt, w_last_nxt;

    assign ready_o = rst_n && (r_state == RUN);
    assign busy_o  = (r_state == FLUSH);
    assign w_acc   = valid_i && ready_o;

    for (genvar s = 0; s < NS; s++) begin : g_surv
        localparam logic [IW-1:0] S_IDX = IW'(s);
        logic [IW-1:0] w_pred;
        assign w_pred        = IW'(pred_idx(s, dec_bits_i[s], K));
        assign w_path_nxt[s] = {r_path[w_pred][TBL-2:0], S_IDX[IW-1]};
    end

    tbu_argmin #(
        .NS (NS),
        .W  (PM_WIDTH),
        .IW (IW)
    ) u_argmin (
        .i_pm  (pm_i),
        .o_idx (w_best)
    );

`ifdef TBU_TAIL_TERM_EN
    assign w_sel = '0;
`else
    assign w_sel = w_best;
`endif

    assign w_n_inc    = (r_n == TBL_C) ? TBL_C : r_n + ONE_C;
    assign w_full     = (w_n_inc == TBL_C);
    assign w_sel_path = w_path_nxt[w_sel];
    assign w_rem_ld   = w_full ? TBL_C - ONE_C : w_n_inc;
    // Left-align the undelivered window so the drain always shifts out of the MSB.
    assign w_drain_ld = w_sel_path << (TBL_C - w_rem_ld);

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = 1'b0;
        w_data_nxt  = r_data;
        w_last_nxt  = 1'b0;
        if (r_state == RUN) begin
            if (w_acc) begin
                if (w_full) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_path_nxt[w_best][TBL-1];
                end
                if (last_i) w_state_nxt = FLUSH;
            end
        end else begin
            if (r_rem != '0) begin
                w_valid_nxt = 1'b1;
                w_data_nxt  = r_drain[TBL-1];
                w_last_nxt  = (r_rem == ONE_C);
            end
            if (r_rem <= ONE_C) w_state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_path  <= '0;
            r_n     <= '0;
            r_rem   <= '0;
            r_drain <= '0;
            r_data  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            if (r_state == RUN) begin
                if (w_acc) begin
                    r_path <= w_path_nxt;
                    r_n    <= w_n_inc;
                    if (last_i) begin
                        r_drain <= w_drain_ld;
                        r_rem   <= w_rem_ld;
                    end
                end
            end else begin
                r_drain <= r_drain << 1;
                if (r_rem != '0) r_rem <= r_rem - ONE_C;
                if (r_rem <= ONE_C) begin
                    r_path <= '0;
                    r_n    <= '0;
                end
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign last_o  = r_last;

endmodule

// File: tb/tb_tbu_flush.sv
// Randomized bench for tbu_flush against a full-history survivor model.
module tb_tbu_flush;
    localparam int K    = 3;
    localparam int TBL  = 15;
    localparam int PMW  = 8;
    localparam int NS   = 4;
    localparam int HMAX = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid_i = 1'b0;
    logic              last_i = 1'b0;
    logic [NS-1:0]     dec_bits_i = '0;
    logic [NS*PMW-1:0] pm_i = '0;
    logic              ready_o, data_o, valid_o, last_o, busy_o;

    tbu_flush #(.K(K), .TBL(TBL), .PM_WIDTH(PMW), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .last_i(last_i),
        .dec_bits_i(dec_bits_i), .pm_i(pm_i), .data_o(data_o), .valid_o(valid_o),
        .last_o(last_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit d;
        bit l;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fs = 0, fe = 0;
    exp_t eq[$];
    bit   rxq[$];
    int   last_cnt = 0, rdy_low = 0;
    bit   hist[NS][HMAX];
    bit   nh[NS][HMAX];
    int   hlen = 0, m_n = 0;
    bit   in_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Model: every state keeps its full decoded history; output is the bit TBL symbols back.
    task automatic model_accept(input logic [NS-1:0] d, input logic [NS*PMW-1:0] pm,
                                input bit lst, input int e);
        int   best, sel, rem, p;
        exp_t x;
        best = 0;
        for (int i = 1; i < NS; i++)
            if (pm[i*PMW +: PMW] < pm[best*PMW +: PMW]) best = i;
        for (int s = 0; s < NS; s++) begin
            p = ((s * 2) + int'(d[s])) % NS;
            for (int j = 0; j < hlen; j++) nh[s][j] = hist[p][j];
            nh[s][hlen] = ((s >> (K - 2)) & 1) != 0;
        end
        hlen++;
        for (int s = 0; s < NS; s++)
            for (int j = 0; j < hlen; j++) hist[s][j] = nh[s][j];
        if (m_n < TBL) m_n++;
        if (m_n == TBL) begin
            x.cyc = e; x.d = hist[best][hlen-TBL]; x.l = 1'b0;
            eq.push_back(x);
        end
        if (lst) begin
`ifdef TBU_TAIL_TERM_EN
            sel = 0;
`else
            sel = best;
`endif
            rem = (m_n == TBL) ? TBL - 1 : m_n;
            for (int i = 0; i < rem; i++) begin
                x.cyc = e + 1 + i; x.d = hist[sel][hlen-rem+i]; x.l = (i == rem - 1);
                eq.push_back(x);
            end
            fs = e; fe = e + rem;
            hlen = 0; m_n = 0;
        end
    endtask

    always @(posedge clk) begin
        bit exp_v, exp_b;
        #1;
        cyc++;
        if (!rst_n) begin
            chk("rst_valid_o", valid_o, 0);
            chk("rst_data_o", data_o, 0);
            chk("rst_last_o", last_o, 0);
            chk("rst_busy_o", busy_o, 0);
            chk("rst_ready_o", ready_o, 0);
        end else begin
            while (eq.size() > 0 && eq[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missed_bit actual=none required=bit_at_edge_%0d", eq[0].cyc);
                void'(eq.pop_front());
            end
            exp_v = (eq.size() > 0) && (eq[0].cyc == cyc);
            chk("valid_o", valid_o, exp_v);
            if (exp_v) begin
                if (valid_o) begin
                    chk("data_o", data_o, eq[0].d);
                    chk("last_o", last_o, eq[0].l);
                end
                void'(eq.pop_front());
            end else begin
                chk("last_o_idle", last_o, 0);
            end
            exp_b = (cyc >= fs) && (cyc < fe);
            chk("busy_o", busy_o, exp_b);
            chk("ready_o", ready_o, !exp_b);
            if (valid_o) begin
                rxq.push_back(data_o);
                if (last_o) last_cnt++;
            end
            if (!ready_o) rdy_low++;
        end
    end

    task automatic send(input logic [NS-1:0] d, input logic [NS*PMW-1:0] pm,
                        input bit lst, input int vpct);
        int g;
        bit done;
        g = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            valid_i = (int'($urandom_range(99)) < vpct);
            if (valid_i) begin
                dec_bits_i = d; pm_i = pm; last_i = lst;
            end else begin
                dec_bits_i = NS'($urandom); pm_i = $urandom; last_i = 1'($urandom);
            end
            if (valid_i && ready_o) begin
                model_accept(d, pm, lst, cyc + 1);
                done = 1;
            end else if (++g > 400) begin
                chk("send_timeout", 0, 1);
                done = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0; last_i = 1'b0;
        end
    endtask

    // Encoder-consistent frame: the true state carries the min metric and the true decision.
    task automatic enc_frame(input int len, input int vpct, input int pat, output int b0);
        int                st, nst;
        bit                u;
        logic [NS-1:0]     d;
        logic [NS*PMW-1:0] pm;
        st = 0; in_q.delete(); b0 = rxq.size();
        for (int i = 0; i < len; i++) begin
            u   = (pat == 1) ? ((i % 4) != 1) : 1'($urandom_range(1));
            nst = (int'(u) << (K - 2)) | (st >> 1);
            d   = NS'($urandom);
            d[nst] = (st & 1) != 0;
            for (int s = 0; s < NS; s++)
                pm[s*PMW +: PMW] = (s == nst) ? 8'd0 : 8'($urandom_range(255, 1));
            in_q.push_back(u);
            send(d, pm, i == len - 1, vpct);
            st = nst;
        end
    endtask

    task automatic check_frame(input string nm, input int b0, input int len);
        chk({nm, "_len"}, rxq.size() - b0, len);
        for (int i = 0; i < len; i++)
            if (b0 + i < rxq.size()) chk({nm, "_bit"}, rxq[b0+i], in_q[i]);
    endtask

    function automatic int ones_from(input int b0);
        int c;
        c = 0;
        for (int i = b0; i < rxq.size(); i++) c += int'(rxq[i]);
        return c;
    endfunction

    initial begin
        int b0, lc, rl, flen;
        repeat (3) @(negedge clk);
        chk("reset_ready_low", ready_o, 0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", ready_o, 1);
        chk("post_reset_busy", busy_o, 0);
        idle(2);

        // All-zero stream, 40 symbols.
        b0 = rxq.size(); lc = last_cnt; rl = rdy_low;
        for (int i = 0; i < 40; i++) send('0, {8'd5, 8'd5, 8'd5, 8'd0}, i == 39, 100);
        @(negedge clk); valid_i = 1'b0; last_i = 1'b0;
        chk("zero_run_bits", rxq.size() - b0, 26);
        idle(TBL + 4);
        chk("zero_total_bits", rxq.size() - b0, 40);
        chk("zero_ones", ones_from(b0), 0);
        chk("zero_last_cnt", last_cnt - lc, 1);
        chk("zero_ready_low", rdy_low - rl, 14);

        // 1011 repeated with 50% valid.
        enc_frame(48, 50, 1, b0);
        idle(TBL + 4);
        check_frame("p1011", b0, 48);

        // Short frame of 5 symbols.
        lc = last_cnt; rl = rdy_low;
        enc_frame(5, 100, 0, b0);
        idle(8);
        check_frame("short5", b0, 5);
        chk("short5_last_cnt", last_cnt - lc, 1);
        chk("short5_ready_low", rdy_low - rl, 5);

        // Equal metrics everywhere: state 0 wins every tie.
        b0 = rxq.size();
        for (int i = 0; i < 20; i++) send('0, {4{8'd7}}, i == 19, 100);
        idle(TBL + 4);
        chk("tie_len", rxq.size() - b0, 20);
        chk("tie_ones", ones_from(b0), 0);

        // Best metric moves to state 2 on the last symbol.
        b0 = rxq.size();
        for (int i = 0; i < 19; i++) send('0, {8'd9, 8'd9, 8'd9, 8'd0}, 1'b0, 100);
        send('0, {8'd9, 8'd0, 8'd9, 8'd9}, 1'b1, 100);
        idle(TBL + 4);
        chk("best2_len", rxq.size() - b0, 20);
`ifdef TBU_TAIL_TERM_EN
        chk("best2_final_bit", rxq[rxq.size()-1], 0);
        chk("best2_ones", ones_from(b0), 0);
`else
        chk("best2_final_bit", rxq[rxq.size()-1], 1);
        chk("best2_ones", ones_from(b0), 1);
`endif

        // Random decisions and narrow-range metrics (frequent ties), random lengths.
        for (int f = 0; f < 6; f++) begin
            logic [NS*PMW-1:0] pm;
            flen = int'($urandom_range(35, 1));
            b0 = rxq.size();
            for (int i = 0; i < flen; i++) begin
                for (int s = 0; s < NS; s++) pm[s*PMW +: PMW] = 8'($urandom_range(3));
                send(NS'($urandom), pm, i == flen - 1, 60);
            end
            idle(TBL + 4);
            chk("rand_frame_len", rxq.size() - b0, flen);
        end

        // Reset on the third flush cycle, then a clean frame.
        enc_frame(20, 100, 0, b0);
        repeat (3) begin
            @(negedge clk); valid_i = 1'b0; last_i = 1'b0;
        end
        lc = last_cnt;
        rst_n = 1'b0;
        eq.delete(); fs = 0; fe = 0; hlen = 0; m_n = 0;
        #1;
        chk("midrst_valid_o", valid_o, 0);
        chk("midrst_last_o", last_o, 0);
        chk("midrst_data_o", data_o, 0);
        chk("midrst_busy_o", busy_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_back", ready_o, 1);
        idle(3);
        chk("midrst_no_last", last_cnt - lc, 0);
        enc_frame(5, 70, 0, b0);
        idle(10);
        check_frame("after_rst", b0, 5);
        chk("after_rst_last_cnt", last_cnt - lc, 1);

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
